map_port_arbiter: RTL and testbench

Round-robin arbiter that shares the single-port tile-map BRAM (32×36 tiles, 4 bits each) among several requesters, for example Pac-Man movement, ghost movement, the pellet/score logic and the tile renderer. Each requester issues one read or write at a time with a valid/ready handshake. The block serialises the requests onto one memory port and routes each response back to its owner with a fixed two-cycle latency. It sits between the game-logic blocks and the map RAM, replacing direct combinational indexing into the map array.

---
 rtl/map_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_map_port_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/map_port_arbiter.sv
// map_port_arbiter: round-robin arbiter sharing the single-port tile-map BRAM
// among N_REQ requesters. Grant is combinational (cycle T), the BRAM command
// is registered (T+1) and the response is strobed back to the owner at T+2.
// Optional write path: define MAP_ARB_WRITE_EN to enable writes; without it
// every transfer is performed as a read.
module map_port_arbiter #(
    parameter int N_REQ     = 4,
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 4,
    parameter int MAP_TILES = 1152
) (
    input  logic                       vga_pix_clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ-1:0]           req_we,
    input  logic [N_REQ*ADDR_W-1:0]    req_addr,
    input  logic [N_REQ*DATA_W-1:0]    req_wdata,
    output logic [N_REQ-1:0]           rsp_valid,
    output logic [DATA_W-1:0]          rsp_data,
    output logic                       rsp_err,
    output logic                       mem_en,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    // One extra bit so the limit compare never truncates MAP_TILES.
    localparam logic [ADDR_W:0] MAP_LIM = MAP_TILES[ADDR_W:0];

    logic [PW-1:0]     prio_q, prio_d;
    logic [N_REQ-1:0]  gnt_oh;
    logic [PW-1:0]     gnt_idx;
    logic              gnt_any;

    logic [ADDR_W-1:0] sel_addr;
    logic              sel_we;
    logic [DATA_W-1:0] sel_wdata;
    logic              in_range;

    // Issue stage (S1)
    logic              s1_vld_q;
    logic [PW-1:0]     s1_owner_q;
    logic              s1_rd_q;
    logic              s1_err_q;
    logic [DATA_W-1:0] s1_data_q;
    logic              mem_en_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    // Response stage (S2)
    logic [N_REQ-1:0]  owner_oh;
    logic [N_REQ-1:0]  rsp_valid_q;
    logic              rsp_err_q;
    logic              s2_rd_q;
    logic [DATA_W-1:0] s2_data_q;

    // Round-robin search starting at prio; grants are suppressed in reset.
    always_comb begin
        int idx;
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(prio_q) + k) % N_REQ;
            if (rst_n && !gnt_any && req_valid[idx]) begin
                gnt_any     = 1'b1;
                gnt_idx     = PW'(idx);
                gnt_oh[idx] = 1'b1;
            end
        end
        prio_d = gnt_any ? PW'((int'(gnt_idx) + 1) % N_REQ) : prio_q;
    end

    assign req_ready = gnt_oh;

    assign sel_addr = req_addr[gnt_idx*ADDR_W +: ADDR_W];
    assign in_range = ({1'b0, sel_addr} < MAP_LIM);

`ifdef MAP_ARB_WRITE_EN
    assign sel_we    = req_we[gnt_idx];
    assign sel_wdata = req_wdata[gnt_idx*DATA_W +: DATA_W];
`else
    // Write inputs are ignored when the write path is compiled out.
    logic unused_wr;
    assign unused_wr = ^{req_we, req_wdata};
    assign sel_we    = 1'b0;
    assign sel_wdata = '0;
`endif

    // Priority pointer and the issue stage: capture the granted request
    always_ff @(posedge vga_pix_clk) begin
        if (!rst_n) begin
            prio_q      <= '0;
            s1_vld_q    <= 1'b0;
            s1_owner_q  <= '0;
            s1_rd_q     <= 1'b0;
            s1_err_q    <= 1'b0;
            s1_data_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            prio_q     <= prio_d;
            s1_vld_q   <= gnt_any;
            s1_owner_q <= gnt_idx;
            s1_rd_q    <= gnt_any & in_range & ~sel_we;
            s1_err_q   <= gnt_any & ~in_range;
            // Writes echo their data; reads and errors carry zero here.
            s1_data_q  <= (gnt_any & in_range & sel_we) ? sel_wdata : '0;
            mem_en_q   <= gnt_any & in_range;
            mem_we_q   <= gnt_any & in_range & sel_we;
            if (gnt_any) begin
                mem_addr_q  <= sel_addr;
                mem_wdata_q <= sel_wdata;
            end
        end
    end

    // Owner decode for the response strobe
    always_comb begin
        owner_oh = '0;
        owner_oh[s1_owner_q] = s1_vld_q;
    end

    // Response stage: strobe the owner, flag out-of-range accesses
    always_ff @(posedge vga_pix_clk) begin
        if (!rst_n) begin
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            s2_rd_q     <= 1'b0;
            s2_data_q   <= '0;
        end else begin
            rsp_valid_q <= owner_oh;
            rsp_err_q   <= s1_vld_q & s1_err_q;
            s2_rd_q     <= s1_vld_q & s1_rd_q;
            s2_data_q   <= s1_vld_q ? s1_data_q : '0;
        end
    end

    // BRAM read data lands in the S2 cycle, so reads bypass the S2 data register.
    assign rsp_data  = s2_rd_q ? mem_rdata : s2_data_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_map_port_arbiter.sv
// Directed bench for map_port_arbiter with a behavioural synchronous BRAM.
module tb_map_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 11;
    localparam int DW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid, req_ready, req_we, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   rsp_data, mem_wdata, mem_rdata;
    logic            rsp_err, mem_en, mem_we;
    logic [AW-1:0]   mem_addr;

    // Preload port into the BRAM model
    logic            pl_en;
    logic [AW-1:0]   pl_addr;
    logic [DW-1:0]   pl_data;
    logic [DW-1:0]   mem [0:2047];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    map_port_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAP_TILES(1152)) dut (
        .vga_pix_clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Synchronous single-port BRAM, read data one cycle after enable
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr] <= mem_wdata;
                mem_rdata     <= mem_wdata;
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_we[i]             = we;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        next();
        pl_en = 1'b0;
    endtask

    logic [N-1:0] e;

    initial begin
        rst_n = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        next();
        preload(11'd33,  4'hA);
        preload(11'd100, 4'h8);
        preload(11'd37,  4'h3);

        // Reset state; requests must not be granted while in reset
        req_valid = 4'b1111;
        #1;
        chk("rst_ready", req_ready, 4'b0000);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 11'd0);
        chk("rst_mem_wdata", mem_wdata, 4'h0);
        chk("rst_rsp_valid", rsp_valid, 4'b0000);
        chk("rst_rsp_data", rsp_data, 4'h0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        req_valid = '0;
        next();
        rst_n = 1'b1;
        next();

        // Single read: requester 2 reads tile 33 (prio 0 -> 3)
        set_req(2, 1'b0, 11'd33, 4'h0);
        req_valid = 4'b0100;
        #1;
        chk("rd_ready", req_ready, 4'b0100);
        next();
        req_valid = '0;
        #1;
        chk("rd_mem_en", mem_en, 1'b1);
        chk("rd_mem_we", mem_we, 1'b0);
        chk("rd_mem_addr", mem_addr, 11'd33);
        next();
        chk("rd_rsp_valid", rsp_valid, 4'b0100);
        chk("rd_rsp_data", rsp_data, 4'hA);
        chk("rd_rsp_err", rsp_err, 1'b0);

        // Out of range: requester 3 reads 1152 (prio 3 -> 0)
        next();
        chk("idle_rsp_valid", rsp_valid, 4'b0000);
        set_req(3, 1'b0, 11'd1152, 4'h0);
        req_valid = 4'b1000;
        #1;
        chk("oor_ready", req_ready, 4'b1000);
        next();
        req_valid = '0;
        #1;
        chk("oor_mem_en", mem_en, 1'b0);
        next();
        chk("oor_rsp_valid", rsp_valid, 4'b1000);
        chk("oor_rsp_err", rsp_err, 1'b1);
        chk("oor_rsp_data", rsp_data, 4'h0);

        // Write 0 to tile 100 (holds 8), then read it back the next cycle
        next();
        set_req(1, 1'b1, 11'd100, 4'h0);
        req_valid = 4'b0010;
        #1;
        chk("wr_ready", req_ready, 4'b0010);
        next();
        set_req(0, 1'b0, 11'd100, 4'h0);
        req_valid = 4'b0001;
        #1;
        chk("wr_rd_ready", req_ready, 4'b0001);
        chk("wr_mem_en", mem_en, 1'b1);
        chk("wr_mem_addr", mem_addr, 11'd100);
        chk("wr_mem_wdata", mem_wdata, 4'h0);
`ifdef MAP_ARB_WRITE_EN
        chk("wr_mem_we", mem_we, 1'b1);
`else
        chk("wr_mem_we", mem_we, 1'b0);
`endif
        next();
        req_valid = '0;
        #1;
        chk("wr_rsp_valid", rsp_valid, 4'b0010);
`ifdef MAP_ARB_WRITE_EN
        chk("wr_rsp_data", rsp_data, 4'h0);
`else
        chk("wr_rsp_data", rsp_data, 4'h8);
        chk("wr_rd_mem_we", mem_we, 1'b0);
`endif
        next();
        chk("wrrd_rsp_valid", rsp_valid, 4'b0001);
`ifdef MAP_ARB_WRITE_EN
        chk("wrrd_rsp_data", rsp_data, 4'h0);
`else
        chk("wrrd_rsp_data", rsp_data, 4'h8);
`endif

        // Reset mid-operation: read of 37 granted, reset during T+1
        next();
        set_req(0, 1'b0, 11'd37, 4'h0);
        req_valid = 4'b0001;
        #1;
        chk("mid_ready", req_ready, 4'b0001);
        next();
        req_valid = '0;
        rst_n     = 1'b0;
        #1;
        chk("mid_mem_en", mem_en, 1'b1);
        chk("mid_mem_addr", mem_addr, 11'd37);
        next();
        chk("mid_rsp_valid", rsp_valid, 4'b0000);
        chk("mid_rsp_data", rsp_data, 4'h0);
        chk("mid_rsp_err", rsp_err, 1'b0);
        chk("mid_mem_en0", mem_en, 1'b0);
        chk("mid_mem_addr0", mem_addr, 11'd0);
        rst_n = 1'b1;

        // Fairness: all four requesters valid continuously from reset
        next();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 11'd33, 4'h0);
        req_valid = 4'b1111;
        for (int k = 0; k < 10; k++) begin
            #1;
            e = '0;
            e[k % N] = 1'b1;
            chk($sformatf("rr_ready_%0d", k), req_ready, e);
            if (k >= 2) begin
                e = '0;
                e[(k - 2) % N] = 1'b1;
                chk($sformatf("rr_rsp_%0d", k), rsp_valid, e);
                chk($sformatf("rr_data_%0d", k), rsp_data, 4'hA);
            end
            next();
        end
        req_valid = '0;
        next();
        next();
        chk("end_rsp_valid", rsp_valid, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
